// File: rtl/pico_pkg.sv
// Shared definitions for the pico CPU/memory bus slice.
//   ADDR_W         - width of the shared bus address
//   DATA_W         - width of the shared bus data
//   loader_state_t - program loader FSM states
package pico_pkg;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_LOAD,
    ST_RELEASE
  } loader_state_t;

endpackage

// File: rtl/pico_loader_if.sv
// Write-capable bus segment (address, read enable, write enable, write data).
// Read data travels straight from memory to the CPU, so it is not part of
// this bundle.
//   master - drives the segment (CPU side, or loader toward memory)
//   slave  - observes the segment (loader from CPU, or memory)
interface pico_loader_if;
  import pico_pkg::*;

  logic [ADDR_W-1:0] addr;
  logic              re;
  logic              we;
  logic [DATA_W-1:0] wdata;

  modport master (output addr, re, we, wdata);
  modport slave  (input  addr, re, we, wdata);

endinterface

// File: rtl/pico_loader.sv
// Program loader and bus controller between the CPU and the memory/port
// block. Outside a load it passes the CPU bus straight through. During a
// load it holds the CPU in reset and writes a byte stream to addresses
// 0..LOAD_BYTES-1. It also keeps an 8-bit running sum of the loaded image.
//
// Ports:
//   clk, res            - clock, synchronous active-high reset
//   ld_req              - start a load (honoured only in RUN)
//   rx_valid, rx_data   - incoming byte stream
//   rx_ready            - loader accepts a byte this cycle
//   cpu  (slave)        - bus as driven by the CPU
//   mem  (master)       - bus toward the memory/port block
//   cpu_res             - reset to the CPU
//   ld_busy             - load in progress (LOAD or RELEASE)
//   ld_done             - one-cycle pulse when a load completes
//   ld_sum              - sum mod 256 of bytes accepted in current/last load
module pico_loader
  import pico_pkg::*;
#(
  parameter int LOAD_BYTES = 64,
  parameter bit BOOT_LOAD  = 1'b1
) (
  input  logic              clk,
  input  logic              res,
  input  logic              ld_req,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  output logic              rx_ready,
  pico_loader_if.slave      cpu,
  pico_loader_if.master     mem,
  output logic              cpu_res,
  output logic              ld_busy,
  output logic              ld_done,
  output logic [DATA_W-1:0] ld_sum
);

  // The counter is one bit wider than the address so that a 64-byte image
  // can be counted. Only its low bits form the write address.
  localparam logic [6:0] LAST_IDX = 7'(LOAD_BYTES - 1);

  loader_state_t state;
  logic [6:0]    cnt;
  logic          accept;
  logic          last_byte;

  // Reset overrides the handshake, so no byte is taken while res is high.
  assign rx_ready  = (state == ST_LOAD) && !res;
  assign accept    = rx_valid && rx_ready;
  assign last_byte = accept && (cnt == LAST_IDX);
  assign ld_busy   = (state != ST_RUN);
  assign cpu_res   = res || (state != ST_RUN);

  // Output mux: RUN is pure pass-through. LOAD writes only in acceptance
  // cycles, with write data forced to zero otherwise. RELEASE keeps every
  // enable low. Reset masks both enables whatever the state.
  always_comb begin
    mem.addr  = cnt[ADDR_W-1:0];
    mem.re    = 1'b0;
    mem.we    = 1'b0;
    mem.wdata = '0;
    case (state)
      ST_RUN: begin
        mem.addr  = cpu.addr;
        mem.re    = cpu.re && !res;
        mem.we    = cpu.we && !res;
        mem.wdata = cpu.wdata;
      end
      ST_LOAD: begin
        mem.we = accept;
        if (accept) begin
          mem.wdata = rx_data;
        end
      end
      default: ;
    endcase
  end

  // FSM, byte counter and checksum. ld_done is registered on the last
  // acceptance, so it is high for exactly the single RELEASE cycle.
  always_ff @(posedge clk) begin
    if (res) begin
      state   <= BOOT_LOAD ? ST_LOAD : ST_RUN;
      cnt     <= '0;
      ld_sum  <= '0;
      ld_done <= 1'b0;
    end else begin
      ld_done <= 1'b0;
      case (state)
        ST_RUN: begin
          if (ld_req) begin
            state  <= ST_LOAD;
            cnt    <= '0;
            ld_sum <= '0;
          end
        end
        ST_LOAD: begin
          if (accept) begin
            cnt    <= cnt + 7'd1;
            ld_sum <= ld_sum + rx_data;
            if (last_byte) begin
              state   <= ST_RELEASE;
              ld_done <= 1'b1;
            end
          end
        end
        default: begin
          state <= ST_RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pico_loader.sv
// Self-checking bench for pico_loader. Two instances share the stimulus:
// a 64-byte boot-loading one and a 4-byte one that starts in RUN. Only the
// instance selected by 'sel' is checked; the other one is parked in reset.
// Expected values come from a byte-level model: the next write address is
// the number of bytes accepted so far, and the sum is their total mod 256.
module tb_pico_loader;
  import pico_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       res64, res4, ldReq, rxValid, sel;
  logic [7:0] rxData;

  pico_loader_if cpuBus ();
  pico_loader_if memBus64 ();
  pico_loader_if memBus4 ();

  logic       rxReady64, cpuRes64, busy64, done64;
  logic       rxReady4, cpuRes4, busy4, done4;
  logic [7:0] sum64, sum4;

  pico_loader #(.LOAD_BYTES(64), .BOOT_LOAD(1'b1)) dut64 (
    .clk(clk), .res(res64), .ld_req(ldReq), .rx_valid(rxValid),
    .rx_data(rxData), .rx_ready(rxReady64), .cpu(cpuBus), .mem(memBus64),
    .cpu_res(cpuRes64), .ld_busy(busy64), .ld_done(done64), .ld_sum(sum64)
  );

  pico_loader #(.LOAD_BYTES(4), .BOOT_LOAD(1'b0)) dut4 (
    .clk(clk), .res(res4), .ld_req(ldReq), .rx_valid(rxValid),
    .rx_data(rxData), .rx_ready(rxReady4), .cpu(cpuBus), .mem(memBus4),
    .cpu_res(cpuRes4), .ld_busy(busy4), .ld_done(done4), .ld_sum(sum4)
  );

  // Outputs of whichever instance is under test.
  logic       oReady, oCpuRes, oRe, oWe, oBusy, oDone;
  logic [5:0] oAddr;
  logic [7:0] oWd, oSum;
  assign oReady  = sel ? rxReady4      : rxReady64;
  assign oCpuRes = sel ? cpuRes4       : cpuRes64;
  assign oRe     = sel ? memBus4.re    : memBus64.re;
  assign oWe     = sel ? memBus4.we    : memBus64.we;
  assign oAddr   = sel ? memBus4.addr  : memBus64.addr;
  assign oWd     = sel ? memBus4.wdata : memBus64.wdata;
  assign oBusy   = sel ? busy4         : busy64;
  assign oDone   = sel ? done4         : done64;
  assign oSum    = sel ? sum4          : sum64;

  int total = 0;
  int bad   = 0;
  int expCount;
  int expSum;
  int loadBytes;

  // One comparison: counted, and reported on mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic lr, input logic v,
                               input logic [7:0] d, input logic cre,
                               input logic cwe, input logic [5:0] ca,
                               input logic [7:0] cwd);
    ldReq         = lr;
    rxValid       = v;
    rxData        = d;
    cpuBus.re     = cre;
    cpuBus.we     = cwe;
    cpuBus.addr   = ca;
    cpuBus.wdata  = cwd;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // RUN cycle: the memory side must mirror the CPU exactly.
  task automatic runCycle(input logic lr, input logic v, input logic [7:0] d,
                          input logic cre, input logic cwe,
                          input logic [5:0] ca, input logic [7:0] cwd);
    applyStimulus(lr, v, d, cre, cwe, ca, cwd);
    #1;
    checkOutput("run.cpu_res", 32'(oCpuRes), 32'd0);
    checkOutput("run.rx_ready", 32'(oReady), 32'd0);
    checkOutput("run.mem_addr", 32'(oAddr), 32'(ca));
    checkOutput("run.mem_re", 32'(oRe), 32'(cre));
    checkOutput("run.mem_we", 32'(oWe), 32'(cwe));
    checkOutput("run.mem_wdata", 32'(oWd), 32'(cwd));
    checkOutput("run.busy", 32'(oBusy), 32'd0);
    checkOutput("run.done", 32'(oDone), 32'd0);
    checkOutput("run.sum", 32'(oSum), 32'(expSum));
    if (lr) begin
      expCount = 0;
      expSum   = 0;
    end
    nextCycle();
  endtask

  // LOAD cycle: CPU bus and ld_req are driven with noise that must be ignored.
  task automatic loadCycle(input logic v, input logic [7:0] d);
    applyStimulus(1'($urandom), v, d, 1'b1, 1'b1, 6'($urandom), 8'($urandom));
    #1;
    checkOutput("load.rx_ready", 32'(oReady), 32'd1);
    checkOutput("load.cpu_res", 32'(oCpuRes), 32'd1);
    checkOutput("load.mem_re", 32'(oRe), 32'd0);
    checkOutput("load.mem_we", 32'(oWe), 32'(v));
    checkOutput("load.mem_addr", 32'(oAddr), 32'(expCount % 64));
    checkOutput("load.mem_wdata", 32'(oWd), v ? 32'(d) : 32'd0);
    checkOutput("load.busy", 32'(oBusy), 32'd1);
    checkOutput("load.done", 32'(oDone), 32'd0);
    checkOutput("load.sum", 32'(oSum), 32'(expSum));
    if (v) begin
      expCount++;
      expSum = (expSum + int'(d)) % 256;
    end
    nextCycle();
  endtask

  // The single cycle following the last accepted byte.
  task automatic releaseCycle();
    applyStimulus(1'b1, 1'b1, 8'($urandom), 1'b1, 1'b1, 6'($urandom), 8'($urandom));
    #1;
    checkOutput("release.done", 32'(oDone), 32'd1);
    checkOutput("release.busy", 32'(oBusy), 32'd1);
    checkOutput("release.cpu_res", 32'(oCpuRes), 32'd1);
    checkOutput("release.rx_ready", 32'(oReady), 32'd0);
    checkOutput("release.mem_re", 32'(oRe), 32'd0);
    checkOutput("release.mem_we", 32'(oWe), 32'd0);
    checkOutput("release.sum", 32'(oSum), 32'(expSum));
    nextCycle();
  endtask

  // One cycle of reset on the selected instance, with busy bus inputs.
  task automatic resetCycle();
    if (sel) res4 = 1'b1; else res64 = 1'b1;
    applyStimulus(1'b1, 1'b1, 8'($urandom), 1'b1, 1'b1, 6'($urandom), 8'($urandom));
    #1;
    checkOutput("reset.cpu_res", 32'(oCpuRes), 32'd1);
    checkOutput("reset.rx_ready", 32'(oReady), 32'd0);
    checkOutput("reset.mem_re", 32'(oRe), 32'd0);
    checkOutput("reset.mem_we", 32'(oWe), 32'd0);
    nextCycle();
    if (sel) res4 = 1'b0; else res64 = 1'b0;
    expCount = 0;
    expSum   = 0;
  endtask

  // Stream random bytes with random gaps until the image is complete.
  task automatic streamRest();
    for (int c = 0; c < 2000 && expCount < loadBytes; c++) begin
      loadCycle(1'($urandom), 8'($urandom));
    end
    checkOutput("stream.complete", 32'(expCount), 32'(loadBytes));
  endtask

  initial begin
    sel = 1'b0;
    res64 = 1'b1;
    res4  = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 6'h00, 8'h00);
    loadBytes = 64;
    expCount  = 0;
    expSum    = 0;
    nextCycle();

    // Boot load of 0x00..0x3F with the stream held valid.
    resetCycle();
    for (int i = 0; i < 64; i++) begin
      loadCycle(1'b1, 8'(i));
    end
    releaseCycle();
    checkOutput("boot.sum_const", 32'(oSum), 32'hE0);
    runCycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 6'h00, 8'h00);

    // Pass-through, with stream pulses that must not write.
    runCycle(1'b0, 1'b1, 8'hC3, 1'b0, 1'b1, 6'h3F, 8'h5A);
    runCycle(1'b0, 1'b1, 8'h3C, 1'b1, 1'b0, 6'h10, 8'h00);
    for (int i = 0; i < 6; i++) begin
      runCycle(1'b0, 1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
               6'($urandom), 8'($urandom));
    end

    // Reload requested during a CPU write; random throttled stream.
    runCycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 6'($urandom), 8'($urandom));
    streamRest();
    releaseCycle();
    runCycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 6'h00, 8'h00);

    // Reset after 10 bytes: reload restarts from address 0 with a fresh sum.
    runCycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 6'h00, 8'h00);
    for (int i = 0; i < 10; i++) begin
      loadCycle(1'b1, 8'($urandom));
    end
    resetCycle();
    streamRest();
    releaseCycle();
    runCycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 6'h00, 8'h00);

    // Four-byte instance, comes out of reset in RUN; throttled stream.
    res64 = 1'b1;
    sel = 1'b1;
    loadBytes = 4;
    resetCycle();
    runCycle(1'b0, 1'b1, 8'h77, 1'b0, 1'b0, 6'h05, 8'h11);
    runCycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 6'h00, 8'h00);
    loadCycle(1'b0, 8'h12);
    loadCycle(1'b1, 8'hFF);
    loadCycle(1'b0, 8'h34);
    loadCycle(1'b1, 8'h01);
    loadCycle(1'b0, 8'h56);
    loadCycle(1'b1, 8'h80);
    loadCycle(1'b0, 8'h78);
    loadCycle(1'b1, 8'h80);
    releaseCycle();
    checkOutput("throttle.sum_const", 32'(oSum), 32'h00);
    runCycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 6'h2A, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
